// File: rtl/test_pattern_applier_pkg.sv
// Shared types and constants for the on-chip test pattern applier.
// TPA_MISR_POLY is only consumed when TPA_MISR_EN is defined.
package test_applier_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        APPLY     = 3'd3,
        SETTLE    = 3'd4,
        COMPARE   = 3'd5,
        DONE      = 3'd6
    } applierState;

    localparam int VEC_W_DEF      = 34;
    localparam int RESP_W_DEF     = 34;
    localparam int ADDR_W_DEF     = 10;
    localparam int SETTLE_CYC_DEF = 2;
    localparam int CNT_W_DEF      = 16;

    // Feedback taps for the response MISR; sliced down to RESP_W by the user.
    localparam logic [63:0] TPA_MISR_POLY = 64'h0000_0002_0000_0057;

    // Width of one pattern-memory word: {stimulus, expected response}.
    function automatic int patWidth(input int vecW, input int respW);
        return vecW + respW;
    endfunction

endpackage

// File: rtl/test_pattern_applier_resp_misr.sv
// Multiple-input signature register compacting core responses.
// Present in the build only when TPA_MISR_EN is defined.
module resp_misr
    import test_applier_pkg::*;
#(
    parameter int RESP_W = RESP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [RESP_W-1:0] data_in,
    output logic [RESP_W-1:0] sig
);

    localparam logic [RESP_W-1:0] POLY = TPA_MISR_POLY[RESP_W-1:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= {sig[RESP_W-2:0], sig[RESP_W-1]} ^ data_in ^ (sig[RESP_W-1] ? POLY : '0);
        end
    end

endmodule

// File: rtl/test_pattern_applier.sv
// Plays stored {stimulus, expected} patterns into the core under test and tallies mismatches.
// Optional response signature output enabled by defining TPA_MISR_EN.
module test_pattern_applier
    import test_applier_pkg::*;
#(
    parameter int VEC_W      = VEC_W_DEF,
    parameter int RESP_W     = RESP_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W:0]           num_pats,
    output logic                      pat_rd,
    output logic [ADDR_W-1:0]         pat_addr,
    input  logic                      pat_valid,
    input  logic [VEC_W+RESP_W-1:0]   pat_data,
    output logic [VEC_W-1:0]          cut_in,
    input  logic [RESP_W-1:0]         cut_out,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CNT_W-1:0]          fail_count,
    output logic [ADDR_W-1:0]         first_fail_idx,
    output logic [RESP_W-1:0]         first_fail_diff,
`ifdef TPA_MISR_EN
    output logic [RESP_W-1:0]         sig,
`endif
    output applierState               dbgState
);

    // Handshake: pat_rd is a one-cycle request; the first pat_valid seen in WAIT_DATA
    // completes it. pat_valid in any other state carries no meaning and is ignored.

    localparam int PAT_W = patWidth(VEC_W, RESP_W);
    localparam int SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [ADDR_W:0] MAX_PATS = {1'b1, {ADDR_W{1'b0}}};

    applierState       state;
    logic [ADDR_W:0]   numPats;
    logic [ADDR_W:0]   clampedNum;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idxNext;
    logic [VEC_W-1:0]  stimReg;
    logic [RESP_W-1:0] expResp;
    logic [RESP_W-1:0] diff;
    logic [SW-1:0]     settleCnt;
    logic              startOk;
    logic              lastPat;

    assign dbgState   = state;
    assign clampedNum = (num_pats > MAX_PATS) ? MAX_PATS : num_pats;
    assign startOk    = start && (state == IDLE || state == DONE);
    assign diff       = expResp ^ cut_out;
    assign idxNext    = idx + ADDR_W'(1);
    assign lastPat    = ({1'b0, idx} + (ADDR_W+1)'(1)) == numPats;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pat_rd          <= 1'b0;
            pat_addr        <= '0;
            cut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
            numPats         <= '0;
            idx             <= '0;
            stimReg         <= '0;
            expResp         <= '0;
            settleCnt       <= '0;
        end else begin
            pat_rd <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (startOk) begin
                        numPats         <= clampedNum;
                        idx             <= '0;
                        fail_count      <= '0;
                        first_fail_idx  <= '0;
                        first_fail_diff <= '0;
                        if (clampedNum == '0) begin
                            // Empty run: nothing to apply, report success immediately.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            pat_rd   <= 1'b1;
                            pat_addr <= '0;
                        end
                    end
                end
                FETCH: state <= WAIT_DATA;
                WAIT_DATA: begin
                    if (pat_valid) begin
                        stimReg <= pat_data[PAT_W-1 -: VEC_W];
                        expResp <= pat_data[RESP_W-1:0];
                        state   <= APPLY;
                    end
                end
                APPLY: begin
                    cut_in    <= stimReg;
                    settleCnt <= '0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt == SW'(SETTLE_CYC - 1)) state <= COMPARE;
                    else settleCnt <= settleCnt + SW'(1);
                end
                COMPARE: begin
                    if (diff != '0) begin
                        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                        if (fail_count == '0) begin
                            first_fail_idx  <= idx;
                            first_fail_diff <= diff;
                        end
                    end
                    if (lastPat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (diff == '0) && (fail_count == '0);
                    end else begin
                        idx      <= idxNext;
                        pat_addr <= idxNext;
                        pat_rd   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TPA_MISR_EN
    resp_misr #(.RESP_W(RESP_W)) u_misr (
        .clk     (clk),
        .reset   (reset),
        .clear   (startOk),
        .enable  (state == COMPARE),
        .data_in (cut_out),
        .sig     (sig)
    );
`endif

endmodule

// File: tb/tb_test_pattern_applier.sv
// Directed bench for test_pattern_applier: memory model with configurable latency and a
// combinational core model; results checked with immediate assertions.
module tb_test_pattern_applier;
    import test_applier_pkg::*;

    localparam int VEC_W  = 34;
    localparam int RESP_W = 34;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [ADDR_W:0]         num_pats;
    logic                    pat_rd;
    logic [ADDR_W-1:0]       pat_addr;
    logic                    pat_valid;
    logic [VEC_W+RESP_W-1:0] pat_data;
    logic [VEC_W-1:0]        cut_in;
    logic [RESP_W-1:0]       cut_out;
    logic                    busy, done, pass;
    logic [CNT_W-1:0]        fail_count;
    logic [ADDR_W-1:0]       first_fail_idx;
    logic [RESP_W-1:0]       first_fail_diff;
`ifdef TPA_MISR_EN
    logic [RESP_W-1:0]       sig;
`endif
    applierState             dbgState;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdCount = 0;
    int memLat = 1;
    logic [VEC_W-1:0]  memStim [0:15];
    logic [RESP_W-1:0] memExp  [0:15];

    test_pattern_applier dut (
        .clk(clk), .reset(reset), .start(start), .num_pats(num_pats),
        .pat_rd(pat_rd), .pat_addr(pat_addr), .pat_valid(pat_valid), .pat_data(pat_data),
        .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx), .first_fail_diff(first_fail_diff),
`ifdef TPA_MISR_EN
        .sig(sig),
`endif
        .dbgState(dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [RESP_W-1:0] coreFn(input logic [VEC_W-1:0] s);
        return {s[16:0], s[33:17]} ^ 34'h1_5A5A_A5A5;
    endfunction

    assign cut_out = coreFn(cut_in);

    // pattern memory: answers each read after memLat cycles
    logic [ADDR_W-1:0] rdAddr;
    int waitCnt = 0;
    logic pending = 1'b0;
    always @(posedge clk) begin
        pat_valid <= 1'b0;
        pat_data  <= {VEC_W+RESP_W{1'b1}};
        if (pat_rd) begin
            rdCount <= rdCount + 1;
            rdAddr  <= pat_addr;
            if (memLat == 1) begin
                pat_valid <= 1'b1;
                pat_data  <= {memStim[pat_addr[3:0]], memExp[pat_addr[3:0]]};
            end else begin
                pending <= 1'b1;
                waitCnt <= memLat - 1;
            end
        end else if (pending) begin
            if (waitCnt <= 1) begin
                pat_valid <= 1'b1;
                pat_data  <= {memStim[rdAddr[3:0]], memExp[rdAddr[3:0]]};
                pending   <= 1'b0;
            end
            waitCnt <= waitCnt - 1;
        end
    end

    // driver tasks
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic startRun(input int n);
        @(negedge clk);
        num_pats = (ADDR_W+1)'(n);
        start = 1'b1;
        stepCycle();
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic waitDone(input int limit);
        while (!done && cyc < limit) stepCycle();
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef TPA_MISR_EN
    function automatic logic [RESP_W-1:0] misrStep(input logic [RESP_W-1:0] s, input logic [RESP_W-1:0] d);
        logic [RESP_W-1:0] p;
        p = TPA_MISR_POLY[RESP_W-1:0];
        return {s[RESP_W-2:0], s[RESP_W-1]} ^ d ^ (s[RESP_W-1] ? p : '0);
    endfunction
`endif

    initial begin
        logic [VEC_W-1:0] heldCut;
        int rdBefore;
        reset = 1'b1;
        start = 1'b0;
        num_pats = '0;
        memStim[0] = 34'h1_2345_6789;
        memStim[1] = 34'h2_AAAA_5555;
        memStim[2] = 34'h0_0F0F_F0F0;
        memStim[3] = 34'h3_FFFF_0001;
        for (int i = 4; i < 16; i++) memStim[i] = VEC_W'($urandom_range(0, 32'hFFFF_FFFF));
        for (int i = 0; i < 16; i++) memExp[i] = coreFn(memStim[i]);
        repeat (3) stepCycle();
        @(negedge clk);
        reset = 1'b0;
        #1;

        check("rst_state", dbgState, IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_cut_in", cut_in, '0);
        check("rst_pat_rd", pat_rd, 1'b0);
        check("rst_pat_addr", pat_addr, '0);

        // 3 matching patterns, 1-cycle memory: 6 cycles each
        startRun(3);
        check("run3_busy", busy, 1'b1);
        waitDone(200);
        check("run3_cycles", cyc, 18);
        check("run3_pass", pass, 1'b1);
        check("run3_fail_count", fail_count, 0);
        check("run3_busy_end", busy, 1'b0);
        check("run3_cut_in_held", cut_in, memStim[2]);
        check("run3_reads", rdCount, 3);

        // 4 patterns, bit 5 of expected response of pattern 2 flipped
        memExp[2] = memExp[2] ^ 34'h20;
        startRun(4);
        waitDone(200);
        check("mis_cycles", cyc, 24);
        check("mis_done", done, 1'b1);
        check("mis_pass", pass, 1'b0);
        check("mis_fail_count", fail_count, 1);
        check("mis_first_idx", first_fail_idx, 2);
        check("mis_first_diff", first_fail_diff, 34'h20);
        memExp[2] = memExp[2] ^ 34'h20;

        // empty run
        rdBefore = rdCount;
        startRun(0);
        check("zero_done", done, 1'b1);
        check("zero_pass", pass, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_fail_count", fail_count, 0);
        repeat (4) stepCycle();
        check("zero_no_reads", rdCount - rdBefore, 0);

        // 5-cycle memory, start pulsed while waiting for data
        memLat = 5;
        rdBefore = rdCount;
        startRun(2);
        stepCycle();
        check("slow_wait_state", dbgState, WAIT_DATA);
        heldCut = cut_in;
        @(negedge clk);
        num_pats = 11'd7;
        start = 1'b1;
        stepCycle();
        @(negedge clk);
        start = 1'b0;
        stepCycle();
        check("slow_still_waiting", dbgState, WAIT_DATA);
        check("slow_cut_in_stable", cut_in, heldCut);
        waitDone(300);
        check("slow_cycles", cyc, 20);
        check("slow_pass", pass, 1'b1);
        check("slow_fail_count", fail_count, 0);
        check("slow_reads", rdCount - rdBefore, 2);
        check("slow_cut_in_last", cut_in, memStim[1]);
`ifdef TPA_MISR_EN
        check("misr_sig", sig, misrStep(misrStep('0, coreFn(memStim[0])), coreFn(memStim[1])));
`endif
        memLat = 1;

        // reset in the middle of SETTLE aborts the run
        memExp[0] = memExp[0] ^ 34'h1;
        startRun(3);
        while (dbgState != SETTLE && cyc < 50) stepCycle();
        check("abort_reached_settle", dbgState, SETTLE);
        @(negedge clk);
        reset = 1'b1;
        stepCycle();
        check("abort_state", dbgState, IDLE);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_cut_in", cut_in, '0);
        check("abort_fail_count", fail_count, 0);
        @(negedge clk);
        reset = 1'b0;
        memExp[0] = memExp[0] ^ 34'h1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
